seq_control_unit: RTL
=====================

# seq_control_unit

Multi-cycle, parametrised successor to the combinational instruction decoder. It owns the program counter, fetches 32-bit instructions over a req/ack instruction-memory port, and decodes them into registered datapath controls. It resolves BZ/BNZ/JMP/JMR internally against the ALU zero flag, and sequences LD/ST through a data-memory handshake. It sits between instruction memory and the register-file/ALU/shifter datapath.

## Interface
Parameters:
- ADDR_W, 8, PC and instruction/data address width
- DATA_W, 16, datapath width; immediate is sign-extended to this
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- imem_req  out  1  instruction fetch request
- imem_addr  out  ADDR_W  fetch address (= pc)
- imem_ack  in  1  instruction valid this cycle
- imem_data  in  32  instruction word
- zero  in  1  ALU zero flag, sampled in EXEC
- ra_data  in  DATA_W  register A value (JMR target)
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store (ST), 0 = load (LD)
- dmem_ack  in  1  data access complete
- load_en  out  1  register-file write strobe
- a_sel, b_sel, dest_sel  out  4 each  register selects
- op_sel  out  4  ALU/shifter function
- const_sel  out  1  B operand = const_out
- const_out  out  DATA_W  sign-extended imm
- data_sel  out  1  write-back from memory
- pc  out  ADDR_W  current instruction address
- halted  out  1  HALT executed
- illegal  out  1  sticky, undefined opcode seen

## Operation
- Fields: opcode [31:27], dest [26:23], A [22:19], B [18:15], imm [18:3] (16 bits, sign-extended/truncated to DATA_W).
- op_sel: ADD 0, SUB 1, AND 4, OR 5, XOR 6, NOT 7, LSL 8, LSR 9.
- Opcodes:
  - 0 NOP
  - 1 MOVA (OR with const 0)
  - 2–7 ADD/SUB/AND/OR/XOR/NOT (reg-reg)
  - 8–12 ADI/SBI/ANI/ORI/XRI (const_sel=1, b_sel=0)
  - 13 MOVB (A/B fields swapped, OR with const 0)
  - 14 LSR, 15 LSL
  - 16 LD (dest ← mem[ra_data])
  - 17 ST (mem[ra_data] ← rb)
  - 18 BZ, 19 BNZ: pc ← pc + sext(imm) if taken, else pc+1
  - 20 JMP: pc ← imm[ADDR_W-1:0]
  - 21 JMR: pc ← ra_data[ADDR_W-1:0]
  - 22 HALT
  - 23–31 illegal: set illegal, execute as NOP.
- FSM: FETCH → DECODE → EXEC → FETCH. LD/ST go EXEC → MEM → FETCH. HALT: EXEC → HALTED, held until rst.
- FETCH: imem_req=1 until imem_ack; IR captured on the ack cycle.
- DECODE: all controls registered from IR; load_en=0.
- EXEC: load_en=1 for opcodes 1–15 only (one-cycle pulse). Branch/jump resolved here. pc updates at end of EXEC for every non-memory instruction.
- MEM: dmem_req=1 and dmem_we set until dmem_ack. For LD, data_sel=1 and load_en=1 in the ack cycle only. pc ← pc+1 on ack.
- PC arithmetic is modulo 2^ADDR_W; pc+1 and branch targets wrap silently.
- Reset: pc=RESET_PC, state FETCH. All other outputs 0, including illegal and halted. Reset overrides any in-flight handshake; req drops the next cycle.

## Timing
- Zero-wait ALU instruction: 3 cycles (FETCH/DECODE/EXEC). Each imem wait cycle adds 1.
- LD/ST: 4 cycles plus dmem wait cycles.
- Controls hold stable from DECODE until leaving EXEC/MEM; load_en is never high outside EXEC/MEM.
- imem_addr stays stable while imem_req is high. An ack without a req is ignored.
- First imem_req is asserted in the cycle after rst deasserts.

## Test plan
- Reset → pc=0, imem_req=1 next cycle, all controls 0. ADI r3,r1,#-2 with zero-wait ack → load_en pulses in cycle 3, const_out=0xFFFE, op_sel=0, const_sel=1, pc=1.
- BZ imm=-1 at pc=5: zero=1 → pc=4; zero=0 → pc=6. JMP imm=0x1FF with ADDR_W=8 → pc=0xFF, then wraps to 0x00 after a NOP.
- LD with dmem_ack delayed 3 cycles → dmem_req high 4 cycles, dmem_we=0; load_en and data_sel high only in the ack cycle.
- Opcode 25 → illegal=1 and stays 1; no load_en; pc advances. HALT → halted=1, imem_req stays 0.
- rst asserted mid-MEM for ST → dmem_req=0 next cycle, pc=RESET_PC, fetch restarts.

Source files
------------

// File: rtl/seq_control_unit_if.sv
`timescale 1ns/1ps
// Instruction- and data-memory handshake bundle between the sequencer (master)
// and the memory system (slave).
interface seq_control_unit_if #(
    parameter int ADDR_W = 8
);
    // Handshake: a request (imem_req / dmem_req) stays high, with address and
    // dmem_we held stable, until the slave answers with a one-cycle ack. The
    // transfer completes on the rising edge where both req and ack are high.
    // An ack that arrives while req is low is ignored.
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_data;
    logic              dmem_req;
    logic              dmem_we;
    logic              dmem_ack;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we,
        input  imem_ack, imem_data, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we,
        output imem_ack, imem_data, dmem_ack
    );
endinterface

// File: rtl/seq_control_unit.sv
`timescale 1ns/1ps
// Multi-cycle sequencer: owns the PC, fetches over imem, decodes into registered
// datapath controls, resolves branches/jumps and sequences LD/ST through dmem.
module seq_control_unit #(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    seq_control_unit_if.master bus,
    input  logic              zero,
    input  logic [DATA_W-1:0] ra_data,
    output logic              load_en,
    output logic [3:0]        a_sel,
    output logic [3:0]        b_sel,
    output logic [3:0]        dest_sel,
    output logic [3:0]        op_sel,
    output logic              const_sel,
    output logic [DATA_W-1:0] const_out,
    output logic              data_sel,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              illegal,
    output logic [2:0]        state_dbg
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    localparam logic [4:0] OP_LD   = 5'd16;
    localparam logic [4:0] OP_ST   = 5'd17;
    localparam logic [4:0] OP_BZ   = 5'd18;
    localparam logic [4:0] OP_BNZ  = 5'd19;
    localparam logic [4:0] OP_JMP  = 5'd20;
    localparam logic [4:0] OP_JMR  = 5'd21;
    localparam logic [4:0] OP_HALT = 5'd22;

    state_t      state;
    logic [31:0] ir;
    logic        imem_req_q;
    logic        dmem_req_q;
    logic        dmem_we_q;
    logic        load_en_q;
    logic        mem_done;

    logic [4:0]  d_opc;
    logic [3:0]  d_a, d_b, d_dest, d_op;
    logic        d_csel;
    logic        d_illegal;
    logic [31:0] d_imm_sx;
    logic [DATA_W-1:0] d_cout;

    logic [4:0]        ir_op;
    logic [31:0]       e_imm_sx;
    logic [31:0]       e_imm_zx;
    logic [31:0]       ra_zx;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_next;

    assign bus.imem_req  = imem_req_q;
    assign bus.imem_addr = pc;
    assign bus.dmem_req  = dmem_req_q;
    assign bus.dmem_we   = dmem_we_q;
    assign state_dbg     = state;

    // Load write-back must coincide with the dmem ack, so it is gated combinationally.
    assign mem_done = (state == S_MEM) && dmem_req_q && bus.dmem_ack;
    assign data_sel = mem_done && !dmem_we_q;
    assign load_en  = load_en_q || (mem_done && !dmem_we_q);

    always_comb begin
        d_opc     = bus.imem_data[31:27];
        d_dest    = bus.imem_data[26:23];
        d_a       = bus.imem_data[22:19];
        d_b       = bus.imem_data[18:15];
        d_imm_sx  = {{16{bus.imem_data[18]}}, bus.imem_data[18:3]};
        d_op      = 4'd0;
        d_csel    = 1'b0;
        d_cout    = '0;
        d_illegal = 1'b0;
        case (d_opc)
            5'd1:  begin d_op = 4'd5; d_csel = 1'b1; d_b = 4'd0; end
            5'd2:  d_op = 4'd0;
            5'd3:  d_op = 4'd1;
            5'd4:  d_op = 4'd4;
            5'd5:  d_op = 4'd5;
            5'd6:  d_op = 4'd6;
            5'd7:  d_op = 4'd7;
            5'd8:  begin d_op = 4'd0; d_csel = 1'b1; d_b = 4'd0; d_cout = d_imm_sx[DATA_W-1:0]; end
            5'd9:  begin d_op = 4'd1; d_csel = 1'b1; d_b = 4'd0; d_cout = d_imm_sx[DATA_W-1:0]; end
            5'd10: begin d_op = 4'd4; d_csel = 1'b1; d_b = 4'd0; d_cout = d_imm_sx[DATA_W-1:0]; end
            5'd11: begin d_op = 4'd5; d_csel = 1'b1; d_b = 4'd0; d_cout = d_imm_sx[DATA_W-1:0]; end
            5'd12: begin d_op = 4'd6; d_csel = 1'b1; d_b = 4'd0; d_cout = d_imm_sx[DATA_W-1:0]; end
            5'd13: begin
                d_a    = bus.imem_data[18:15];
                d_b    = bus.imem_data[22:19];
                d_op   = 4'd5;
                d_csel = 1'b1;
            end
            5'd14: d_op = 4'd9;
            5'd15: d_op = 4'd8;
            default: d_illegal = (d_opc > OP_HALT);
        endcase
    end

    always_comb begin
        ir_op    = ir[31:27];
        e_imm_sx = {{16{ir[18]}}, ir[18:3]};
        e_imm_zx = {16'd0, ir[18:3]};
        ra_zx    = 32'(ra_data);
        pc_inc   = pc + ADDR_W'(1);
        pc_next  = pc_inc;
        case (ir_op)
            OP_BZ:   if (zero)  pc_next = pc + e_imm_sx[ADDR_W-1:0];
            OP_BNZ:  if (!zero) pc_next = pc + e_imm_sx[ADDR_W-1:0];
            OP_JMP:  pc_next = e_imm_zx[ADDR_W-1:0];
            OP_JMR:  pc_next = ra_zx[ADDR_W-1:0];
            default: pc_next = pc_inc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_FETCH;
            pc         <= RESET_PC;
            ir         <= '0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            load_en_q  <= 1'b0;
            a_sel      <= '0;
            b_sel      <= '0;
            dest_sel   <= '0;
            op_sel     <= '0;
            const_sel  <= 1'b0;
            const_out  <= '0;
            halted     <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    // The first cycle after reset only raises the request.
                    if (imem_req_q && bus.imem_ack) begin
                        ir         <= bus.imem_data;
                        imem_req_q <= 1'b0;
                        a_sel      <= d_a;
                        b_sel      <= d_b;
                        dest_sel   <= d_dest;
                        op_sel     <= d_op;
                        const_sel  <= d_csel;
                        const_out  <= d_cout;
                        illegal    <= illegal || d_illegal;
                        state      <= S_DECODE;
                    end else begin
                        imem_req_q <= 1'b1;
                    end
                end
                S_DECODE: begin
                    load_en_q <= (ir_op >= 5'd1) && (ir_op <= 5'd15);
                    state     <= S_EXEC;
                end
                S_EXEC: begin
                    load_en_q <= 1'b0;
                    if (ir_op == OP_LD || ir_op == OP_ST) begin
                        dmem_req_q <= 1'b1;
                        dmem_we_q  <= (ir_op == OP_ST);
                        state      <= S_MEM;
                    end else if (ir_op == OP_HALT) begin
                        pc     <= pc_next;
                        halted <= 1'b1;
                        state  <= S_HALTED;
                    end else begin
                        pc         <= pc_next;
                        imem_req_q <= 1'b1;
                        state      <= S_FETCH;
                    end
                end
                S_MEM: begin
                    if (bus.dmem_ack) begin
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        pc         <= pc_inc;
                        imem_req_q <= 1'b1;
                        state      <= S_FETCH;
                    end
                end
                default: state <= S_HALTED;
            endcase
        end
    end
endmodule
